// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and sizing helpers for the iterative divider
package div_pkg;

   typedef enum logic [1:0] {
      DIV_FREE   = 2'b00,
      DIV_BYZERO = 2'b01,
      DIV_ON     = 2'b10,
      DIV_END    = 2'b11
   } div_state_e;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

   // result_o = {remainder, quotient}
   localparam int DIV_QUO_LSB = 0;
   localparam int DIV_REM_LSB = DIV_WIDTH;

   function automatic int div_cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/div_sub_step.sv
// rtl/div_sub_step.sv - (WIDTH+1)-bit trial subtractor for one restoring-division step
module div_sub_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   minuend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] diff,
   output logic             neg
);

   logic [WIDTH:0] sum;

   // Same invert-and-carry-in form as the adders; the top bit is the borrow.
   assign sum  = minuend + ~{1'b0, divisor} + {{WIDTH{1'b0}}, 1'b1};
   assign diff = sum[WIDTH-1:0];
   assign neg  = sum[WIDTH];

endmodule

// File: rtl/div_iter.sv
// rtl/div_iter.sv - iterative radix-2 restoring divider for MIPS DIV/DIVU
// Optional DIV_EARLY_OUT_EN: finish on the accepting edge when |dividend| < |divisor|.
module div_iter
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 signed_div_i,
   input  logic [WIDTH-1:0]     opdata1_i,
   input  logic [WIDTH-1:0]     opdata2_i,
   input  logic                 start_i,
   input  logic                 annul_i,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 ready_o
);

   localparam int CNT_W = div_cnt_w(WIDTH);

   div_state_e         state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH:0]   work;
   logic [WIDTH-1:0]   dvs_mag;
   logic               neg_dvd, neg_dvs;

   logic               dvd_neg_in, dvs_neg_in;
   logic [WIDTH-1:0]   dvd_mag_in, dvs_mag_in;
   logic               accept, dvs_zero, early_out, iter_done;
   logic [WIDTH-1:0]   diff, quo, rem, quo_fix, rem_fix;
   logic               diff_neg;
   logic [2*WIDTH-1:0] result_nxt;
   logic               ready_nxt;

   assign dvd_neg_in = signed_div_i & opdata1_i[WIDTH-1];
   assign dvs_neg_in = signed_div_i & opdata2_i[WIDTH-1];
   assign dvd_mag_in = dvd_neg_in ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
   assign dvs_mag_in = dvs_neg_in ? (~opdata2_i + WIDTH'(1)) : opdata2_i;

   assign accept    = start_i & ~annul_i;
   assign dvs_zero  = (opdata2_i == '0);
   assign iter_done = (cnt == CNT_W'(WIDTH));

`ifdef DIV_EARLY_OUT_EN
   assign early_out = (dvd_mag_in < dvs_mag_in);
`else
   assign early_out = 1'b0;
`endif

   // Remainder sits above the consumed dividend bits; quotient bits shift in at bit 0.
   assign quo     = work[WIDTH-1:0];
   assign rem     = work[2*WIDTH:WIDTH+1];
   assign quo_fix = (neg_dvd ^ neg_dvs) ? (~quo + WIDTH'(1)) : quo;
   assign rem_fix = neg_dvd ? (~rem + WIDTH'(1)) : rem;

   div_sub_step #(
      .WIDTH(WIDTH)
   ) u_sub_step (
      .minuend (work[2*WIDTH:WIDTH]),
      .divisor (dvs_mag),
      .diff    (diff),
      .neg     (diff_neg)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= DIV_FREE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         DIV_FREE: begin
            if (accept) begin
               if (dvs_zero) begin
                  state_nxt = DIV_BYZERO;
               end else if (early_out) begin
                  state_nxt = DIV_END;
               end else begin
                  state_nxt = DIV_ON;
               end
            end
         end
         DIV_BYZERO: begin
            state_nxt = annul_i ? DIV_FREE : DIV_END;
         end
         DIV_ON: begin
            if (annul_i) begin
               state_nxt = DIV_FREE;
            end else if (iter_done) begin
               state_nxt = DIV_END;
            end
         end
         DIV_END: begin
            if (!start_i) begin
               state_nxt = DIV_FREE;
            end
         end
         default: state_nxt = DIV_FREE;
      endcase
   end

   // Next values of the registered outputs; everything outside END reads as zero.
   always_comb begin
      result_nxt = '0;
      ready_nxt  = (state_nxt == DIV_END);
      if (state_nxt == DIV_END) begin
         case (state)
            DIV_ON:   result_nxt = {rem_fix, quo_fix};
            DIV_FREE: result_nxt = {opdata1_i, {WIDTH{1'b0}}};
            DIV_END:  result_nxt = result_o;
            default:  result_nxt = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_o <= '0;
         ready_o  <= 1'b0;
      end else begin
         result_o <= result_nxt;
         ready_o  <= ready_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         work    <= '0;
         dvs_mag <= '0;
         neg_dvd <= 1'b0;
         neg_dvs <= 1'b0;
      end else if (state == DIV_FREE && state_nxt == DIV_ON) begin
         cnt     <= '0;
         work    <= {{WIDTH{1'b0}}, dvd_mag_in, 1'b0};
         dvs_mag <= dvs_mag_in;
         neg_dvd <= dvd_neg_in;
         neg_dvs <= dvs_neg_in;
      end else if (state == DIV_ON && state_nxt == DIV_ON) begin
         work <= diff_neg ? {work[2*WIDTH-1:0], 1'b0}
                          : {diff, work[WIDTH-1:0], 1'b1};
         cnt  <= cnt + CNT_W'(1);
      end
   end

endmodule
